uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Brief    : FIFO-buffered UART transmitter with CTS flow control, 8N1 frames;
//            define UART_TX_PARITY_EN for 8E1 frames with an even-parity bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
  parameter int BAUD_COUNT = 645,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    data_in,
  input  logic                          valid_in,
  output logic                          ready_out,
  input  logic                          cts_n_in,
  output logic                          tx_out,
  output logic                          busy_out,
  output logic [$clog2(FIFO_DEPTH):0]   count_out
);

  localparam int                 c_AW       = $clog2(FIFO_DEPTH);
  localparam int                 c_BW       = (BAUD_COUNT > 1) ? $clog2(BAUD_COUNT) : 1;
  localparam logic [c_BW-1:0]    c_BAUD_MAX = c_BW'(BAUD_COUNT - 1);
  localparam logic [c_AW:0]      c_FULL     = (c_AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_BW-1:0]   r_baud;
  logic [c_BW-1:0]   w_baud_nxt;
  logic [2:0]        r_bit;
  logic [2:0]        w_bit_nxt;
  logic              r_tx;
  logic              w_tx_nxt;
  logic [7:0]        r_shift;
  logic              w_shift_en;
  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW-1:0]   r_rd_ptr;
  logic [c_AW:0]     r_count;
  logic              w_push;
  logic              w_pop;
  logic              w_baud_end;
  logic              w_can_start;
`ifdef UART_TX_PARITY_EN
  logic              r_parity;
`endif

  assign ready_out   = (r_count < c_FULL);
  assign w_push      = valid_in & ready_out;
  assign w_baud_end  = (r_baud == c_BAUD_MAX);
  // CTS is only consulted here, at the frame-start decision.
  assign w_can_start = (r_count != '0) & ~cts_n_in;

  assign tx_out    = r_tx;
  assign busy_out  = (r_state != S_IDLE) | (r_count != '0);
  assign count_out = r_count;

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;
    w_shift_en  = 1'b0;
    if (r_state != S_IDLE) begin
      w_baud_nxt = w_baud_end ? '0 : r_baud + c_BW'(1);
    end
    case (r_state)
      S_IDLE: begin
        w_baud_nxt = '0;
        w_tx_nxt   = 1'b1;
        if (w_can_start) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
          w_tx_nxt    = 1'b0;
        end
      end
      S_START: begin
        if (w_baud_end) begin
          w_state_nxt = S_DATA;
          w_bit_nxt   = '0;
          w_tx_nxt    = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_baud_end) begin
          w_shift_en = 1'b1;
          if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_nxt = S_PARITY;
            w_tx_nxt    = r_parity;
`else
            w_state_nxt = S_STOP;
            w_tx_nxt    = 1'b1;
`endif
          end else begin
            w_bit_nxt = r_bit + 3'd1;
            w_tx_nxt  = r_shift[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_baud_end) begin
          w_state_nxt = S_STOP;
          w_tx_nxt    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (w_baud_end) begin
          if (w_can_start) begin
            w_pop       = 1'b1;
            w_state_nxt = S_START;
            w_tx_nxt    = 1'b0;
          end else begin
            w_state_nxt = S_IDLE;
            w_tx_nxt    = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_shift  <= '0;
`ifdef UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_AW + 1)'(1);
        2'b01:   r_count <= r_count - (c_AW + 1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_pop) begin
        r_shift <= r_mem[r_rd_ptr];
      end else if (w_shift_en) begin
        r_shift <= {1'b0, r_shift[7:1]};
      end
`ifdef UART_TX_PARITY_EN
      if (w_pop) r_parity <= ^r_mem[r_rd_ptr];
`endif
    end
  end

  // Storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= data_in;
  end

endmodule
`default_nettype wire
